req_arbiter4: RTL
=================

REQ_ARBITER4 -- requirements
Module: req_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one grant is held (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req  input  4  request bits; bit i is requester i, level-sensitive.
REQ-005 grant  output  4  one-hot grant, registered; all zero when idle.
REQ-006 grant_id  output  2  binary index of the granted requester; 0 when idle.
REQ-007 busy  output  1  high exactly when grant is non-zero.
REQ-008 timeout  output  1  one-cycle pulse in the cycle a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 FSM states are IDLE and GRANTED, stored in a registered state.
REQ-010 IDLE, req==0: stay IDLE; grant=0, grant_id=0, busy=0.
REQ-011 IDLE, req!=0: move to GRANTED on the next edge with winner granted, so latency is 1 cycle from req to grant.
REQ-012 Winner selection without the macro is fixed priority: the lowest set index wins (req=4'b1010 -> grant_id=1).
REQ-013 GRANTED: hold grant while req[grant_id]=1 and hold count < MAX_HOLD; other req bits are ignored.
REQ-014 Hold counter: 8 bits, cleared on entry to GRANTED, incremented each GRANTED cycle, saturating.
REQ-015 GRANTED, req[grant_id]=0 on a rising edge: return to IDLE; grant=0 in the following cycle.
REQ-016 GRANTED with MAX_HOLD grant cycles completed: return to IDLE and pulse timeout=1 in the first IDLE cycle.
REQ-017 A released requester is re-arbitrated normally.
REQ-018 Every release, by drop or by timeout, gives at least one IDLE cycle with grant=0.
REQ-019 Simultaneous drop of req[grant_id] and timeout expiry counts as a drop, with timeout=0.
REQ-020 grant, grant_id and busy stay mutually consistent every cycle; grant never has more than one bit set.

Reset
REQ-021 resetn=0 at a rising edge sets state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, hold count=0 and the RR pointer=3.
REQ-022 Reset asserted mid-grant clears grant at that edge, whatever the value of req.
REQ-023 The first arbitration after reset release is on the first edge with resetn=1 and req!=0.

Configuration
REQ-024 Macro ROUND_ROBIN_EN, when defined, makes winner selection round-robin.
REQ-025 Round-robin search starts at index last_grant+1 mod 4 and takes the first set bit, wrapping.
REQ-026 last_grant updates on each grant and is 3 after reset, so first priority goes to index 0.
REQ-027 Without ROUND_ROBIN_EN, selection is fixed priority (REQ-012) and no pointer register is built.
REQ-028 Latency, release rules and the timeout pulse are identical in both builds.

Verification
REQ-029 Reset then req=4'b0100 held 3 cycles, then 0: grant=4'b0100, grant_id=2 from the cycle after req rises, for 3 cycles; then grant=0, busy=0.
REQ-030 req=4'b1111 constant, MAX_HOLD=8, fixed priority: grant=0001 for 8 cycles, one idle cycle with timeout=1, then grant=0001 again.
REQ-031 Same stimulus with ROUND_ROBIN_EN: grant sequence 0001, 0010, 0100, 1000, 0001, each held 8 cycles, one idle cycle between grants.
REQ-032 Grant 0010 active, raise req[0]: grant stays 0010 until req[1] drops; grant=0001 follows after one idle cycle.
REQ-033 resetn=0 for one edge during grant=1000 with req held: grant=0 the next cycle; grant=1000 one cycle after resetn=1.
REQ-034 req=0 for 20 cycles after reset: grant, grant_id, busy and timeout all 0 throughout.

Source files
------------

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: one registered grant at a time, each grant capped at MAX_HOLD cycles.
// Fixed priority by default; define ROUND_ROBIN_EN for a rotating search that starts after the last winner.
module req_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANTED} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] win_id;

`ifdef ROUND_ROBIN_EN
  logic [1:0] last_grant;
  logic [1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    win_id = 2'(last_grant + 2'd1);
    idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = 2'(last_grant + 2'd1 + 2'(k));
      if (req[idx]) win_id = idx;
    end
  end
`else
  always_comb begin
    win_id = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (req[k]) win_id = 2'(k);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= 4'd0;
      grant_id <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
`ifdef ROUND_ROBIN_EN
      last_grant <= 2'd3;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANTED;
            grant    <= 4'd1 << win_id;
            grant_id <= win_id;
            busy     <= 1'b1;
            hold_cnt <= 8'd0;
`ifdef ROUND_ROBIN_EN
            last_grant <= win_id;
`endif
          end
        end
        GRANTED: begin
          // A drop takes precedence over expiry, so a coincident drop never pulses timeout.
          if (!req[grant_id] || hold_cnt >= HOLD_LAST) begin
            state    <= IDLE;
            grant    <= 4'd0;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            timeout  <= req[grant_id];
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
